// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI responder.
`timescale 1ns/1ps
package spi_resp_pkg;
  localparam int NREGS        = 16;
  localparam int AW           = 4;
  localparam int CMD_RD_BIT   = 7;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_MSB = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus one delay flop for
// edge detection. Pulses are one CLK wide and appear two CLK after the pin
// edge, so the action they trigger lands on the third CLK.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q;

  // synchronizer chain and edge-detect delay flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;
endmodule

// File: rtl/spi_responder.sv
// SPI target (CPHA=0, CPOL selectable) with a 16 x 8 register file.
// Command byte: bit 7 = read, bits 3:0 = address. Optional feature macro:
// SPI_RESP_AUTOINC_EN enables address auto-increment bursts; without it,
// only the first data byte of a frame is acted upon.
`timescale 1ns/1ps
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter logic       CPOL   = 1'b0,
  parameter logic [7:0] IDBYTE = 8'h5A
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sck_i,
  input  logic          nss_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o,
  input  logic [AW-1:0] laddr_i,
  input  logic          lwe_i,
  input  logic [7:0]    lwdata_i,
  output logic [7:0]    lrdata_o,
  output logic          wstb_o,
  output logic [AW-1:0] waddr_o
);
  logic sck_lvl, sck_rise, sck_fall;
  logic nss_lvl, nss_rise, nss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sck_i),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));

  // nSS resets low so a reset taken mid-frame cannot fake a frame start;
  // the frame is ignored until the master raises and lowers nSS again.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_nss (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(nss_i),
    .level_o(nss_lvl), .rise_o(nss_rise), .fall_o(nss_fall));

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_sync = &{1'b0, sck_lvl, nss_lvl, mosi_rise, mosi_fall};

  logic lead, trail;
  assign lead  = CPOL ? sck_fall : sck_rise;
  assign trail = CPOL ? sck_rise : sck_fall;

  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      rx_q, rx_d, tx_q, tx_d, rx_byte;
  logic            miso_q, miso_d, oe_q, oe_d, wstb_q, wstb_d, spi_we;
  logic [AW-1:0]   addr_q, addr_d, waddr_q, waddr_d;
  logic [7:0]      regs_q [NREGS];
`ifdef SPI_RESP_AUTOINC_EN
  logic [AW-1:0]   addr_inc;
  assign addr_inc = addr_q + 1'b1;
`endif

  assign rx_byte = {rx_q[6:0], mosi_lvl};

  // state and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      rx_q     <= '0;
      tx_q     <= IDBYTE;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wstb_q   <= 1'b0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wstb_q   <= wstb_d;
      waddr_q  <= waddr_d;
    end
  end

  // bit layer, command decode and frame boundaries; a frame end in the same
  // CLK as the completing lead edge still lets that byte's write commit
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    waddr_d  = waddr_q;
    wstb_d   = 1'b0;
    spi_we   = 1'b0;
    if (state_q != ST_IDLE) begin
      if (lead) begin
        rx_d     = rx_byte;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          tx_d = 8'h00;
          case (state_q)
            ST_CMD: begin
              addr_d = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
              if (rx_byte[CMD_RD_BIT]) begin
                state_d = ST_RDATA;
                tx_d    = regs_q[rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]];
              end else begin
                state_d = ST_WDATA;
              end
            end
            ST_WDATA: begin
              spi_we  = 1'b1;
              wstb_d  = 1'b1;
              waddr_d = addr_q;
`ifdef SPI_RESP_AUTOINC_EN
              addr_d  = addr_inc;
`else
              state_d = ST_SKIP;
`endif
            end
            ST_RDATA: begin
`ifdef SPI_RESP_AUTOINC_EN
              addr_d  = addr_inc;
              tx_d    = regs_q[addr_inc];
`else
              state_d = ST_SKIP;
`endif
            end
            default: ;
          endcase
        end
      end
      // The first trail after a byte boundary presents bit 7 of the freshly
      // loaded byte; later trails shift.
      if (trail) begin
        if (bitcnt_q == 3'd0) begin
          miso_d = tx_q[7];
        end else begin
          miso_d = tx_q[6];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end
    if (nss_fall) begin
      state_d  = ST_CMD;
      bitcnt_d = '0;
      tx_d     = IDBYTE;
      miso_d   = IDBYTE[7];
      oe_d     = 1'b1;
    end
    if (nss_rise) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      miso_d   = 1'b0;
      oe_d     = 1'b0;
    end
  end

  // register file; an SPI commit beats a local write to the same address
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (spi_we && addr_q == AW'(i))
          regs_q[i] <= rx_byte;
        else if (lwe_i && laddr_i == AW'(i))
          regs_q[i] <= lwdata_i;
      end
    end
  end

  assign lrdata_o  = regs_q[laddr_i];
  assign miso_o    = miso_q;
  assign miso_oe_o = oe_q;
  assign wstb_o    = wstb_q;
  assign waddr_o   = waddr_q;
endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder in mode 0: a bit-banged master, a scoreboard of
// expected MISO bytes and a local model of the register file.
`timescale 1ns/1ps
module tb_spi_responder;
  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst, sck, nss, mosi, lwe;
  logic [3:0] laddr;
  logic [7:0] lwdata;
  logic       miso, miso_oe, wstb;
  logic [7:0] lrdata;
  logic [3:0] waddr;

  spi_responder dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .nss_i(nss), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe),
    .laddr_i(laddr), .lwe_i(lwe), .lwdata_i(lwdata), .lrdata_o(lrdata),
    .wstb_o(wstb), .waddr_o(waddr));

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] model [16];
  int         wstb_cnt = 0, wstb_run = 0, wstb_maxrun = 0, cnt0;
  logic [3:0] wstb_addr = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wstb === 1'b1) begin
      wstb_cnt++;
      wstb_run++;
      wstb_addr = waddr;
      if (wstb_run > wstb_maxrun) wstb_maxrun = wstb_run;
    end else begin
      wstb_run = 0;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input int a);
    laddr = 4'(a);
    #1;
    check_val($sformatf("reg_%0h", a), lrdata, model[a]);
  endtask

  task automatic check_all_regs();
    for (int a = 0; a < 16; a++) check_reg(a);
  endtask

  task automatic frame_begin();
    nss = 1'b0;
    clks(HP);
  endtask

  task automatic frame_end();
    clks(HP);
    nss = 1'b1;
    clks(2 * HP);
  endtask

  // One byte from the master. Optionally pushes the expected MISO byte,
  // stops after nbits, fires a local write in the same CLK as the SPI
  // commit, or raises nSS together with the last lead edge.
  task automatic spi_byte(input logic [7:0] b, input string tag, input bit chk,
                          input logic [7:0] exp, input int nbits = 8,
                          input bit coll = 1'b0, input logic [3:0] caddr = 4'h0,
                          input logic [7:0] cdata = 8'h00, input bit end_last = 1'b0);
    logic [7:0] got;
    logic [7:0] e;
    got = 8'h00;
    if (chk) exp_q.push_back(exp);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      clks(HP);
      got = {got[6:0], miso};
      sck = 1'b1;
      if (i == 0 && end_last) nss = 1'b1;
      if (i == 0 && coll) begin
        clks(2);
        laddr = caddr; lwdata = cdata; lwe = 1'b1;
        clks(1);
        lwe = 1'b0;
        clks(HP - 3);
      end else begin
        clks(HP);
      end
      sck = 1'b0;
    end
    if (chk) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_val(tag, got, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sck = 1'b0; nss = 1'b1; mosi = 1'b0;
    lwe = 1'b0; laddr = '0; lwdata = '0;
    for (int a = 0; a < 16; a++) model[a] = 8'h00;
    clks(3);
    check_val("rst_miso", miso, 0);
    check_val("rst_oe", miso_oe, 0);
    check_val("rst_wstb", wstb, 0);
    check_val("rst_waddr", waddr, 0);
    check_all_regs();
    rst = 1'b0;
    clks(5);

    // write 0xC7 to reg 3
    cnt0 = wstb_cnt;
    frame_begin();
    check_val("oe_in_frame", miso_oe, 1);
    spi_byte(8'h03, "t1_id", 1'b1, 8'h5A);
    spi_byte(8'hC7, "t1_d", 1'b0, 8'h00);
    frame_end();
    model[3] = 8'hC7;
    check_val("t1_wstb_cnt", wstb_cnt - cnt0, 1);
    check_val("t1_wstb_addr", wstb_addr, 3);
    check_val("t1_waddr", waddr, 3);
    check_val("t1_wstb_width", wstb_maxrun, 1);
    check_val("t1_oe_after", miso_oe, 0);
    check_val("t1_miso_after", miso, 0);
    check_reg(3);

    // local write then SPI read of reg 9
    laddr = 4'h9; lwdata = 8'h96; lwe = 1'b1;
    clks(1);
    lwe = 1'b0;
    model[9] = 8'h96;
    check_reg(9);
    frame_begin();
    spi_byte(8'h89, "t2_id", 1'b1, 8'h5A);
    spi_byte(8'h00, "t2_rd", 1'b1, model[9]);
    frame_end();

    // burst write starting at 0xF, then burst read back
    cnt0 = wstb_cnt;
    frame_begin();
    spi_byte(8'h0F, "t3_id", 1'b1, 8'h5A);
    spi_byte(8'h11, "t3_d0", 1'b0, 8'h00);
`ifdef SPI_RESP_AUTOINC_EN
    spi_byte(8'h22, "t3_d1", 1'b0, 8'h00);
    spi_byte(8'h33, "t3_d2", 1'b0, 8'h00);
    model[0] = 8'h22; model[1] = 8'h33;
`else
    spi_byte(8'h22, "t3_skip1", 1'b1, 8'h00);
    spi_byte(8'h33, "t3_skip2", 1'b1, 8'h00);
`endif
    frame_end();
    model[15] = 8'h11;
`ifdef SPI_RESP_AUTOINC_EN
    check_val("t3_wstb_cnt", wstb_cnt - cnt0, 3);
    check_val("t3_wstb_addr", wstb_addr, 1);
`else
    check_val("t3_wstb_cnt", wstb_cnt - cnt0, 1);
    check_val("t3_wstb_addr", wstb_addr, 15);
`endif
    check_all_regs();
    frame_begin();
    spi_byte(8'h8F, "t3r_id", 1'b1, 8'h5A);
    spi_byte(8'h00, "t3r_0", 1'b1, model[15]);
`ifdef SPI_RESP_AUTOINC_EN
    spi_byte(8'h00, "t3r_1", 1'b1, model[0]);
    spi_byte(8'h00, "t3r_2", 1'b1, model[1]);
`else
    spi_byte(8'h00, "t3r_1", 1'b1, 8'h00);
    spi_byte(8'h00, "t3r_2", 1'b1, 8'h00);
`endif
    frame_end();

    // frame aborted after 5 data bits, then a normal frame
    cnt0 = wstb_cnt;
    frame_begin();
    spi_byte(8'h03, "t4_id", 1'b1, 8'h5A);
    spi_byte(8'h3C, "t4_part", 1'b0, 8'h00, 5);
    frame_end();
    check_val("t4_no_wstb", wstb_cnt - cnt0, 0);
    check_reg(3);
    frame_begin();
    spi_byte(8'h05, "t4b_id", 1'b1, 8'h5A);
    spi_byte(8'hA5, "t4b_d", 1'b0, 8'h00);
    frame_end();
    model[5] = 8'hA5;
    check_val("t4b_wstb", wstb_cnt - cnt0, 1);
    check_reg(5);

    // SPI commit and local write in the same CLK: same and different address
    frame_begin();
    spi_byte(8'h02, "t5_id", 1'b1, 8'h5A);
    spi_byte(8'hAA, "t5_d", 1'b0, 8'h00, 8, 1'b1, 4'h2, 8'h55);
    frame_end();
    model[2] = 8'hAA;
    frame_begin();
    spi_byte(8'h06, "t5b_id", 1'b1, 8'h5A);
    spi_byte(8'h3C, "t5b_d", 1'b0, 8'h00, 8, 1'b1, 4'h7, 8'h77);
    frame_end();
    model[6] = 8'h3C; model[7] = 8'h77;
    check_all_regs();

    // nSS rise coincident with the last lead edge still commits
    cnt0 = wstb_cnt;
    frame_begin();
    spi_byte(8'h0A, "t6_id", 1'b1, 8'h5A);
    spi_byte(8'hE1, "t6_d", 1'b0, 8'h00, 8, 1'b0, 4'h0, 8'h00, 1'b1);
    frame_end();
    model[10] = 8'hE1;
    check_val("t6_wstb", wstb_cnt - cnt0, 1);
    check_reg(10);

    // reset pulsed mid-burst
    frame_begin();
    spi_byte(8'h04, "t7_id", 1'b1, 8'h5A);
    spi_byte(8'h44, "t7_d", 1'b0, 8'h00);
    spi_byte(8'h99, "t7_part", 1'b0, 8'h00, 3);
    check_val("t7_oe_pre", miso_oe, 1);
    rst = 1'b1;
    #1;
    for (int a = 0; a < 16; a++) model[a] = 8'h00;
    check_val("t7_oe_rst", miso_oe, 0);
    check_val("t7_miso_rst", miso, 0);
    check_all_regs();
    clks(2);
    rst = 1'b0;
    clks(2);
    cnt0 = wstb_cnt;
    spi_byte(8'hFF, "t7_ign", 1'b0, 8'h00);
    spi_byte(8'h00, "t7_ign2", 1'b0, 8'h00);
    check_val("t7_oe_ignored", miso_oe, 0);
    check_val("t7_no_wstb", wstb_cnt - cnt0, 0);
    frame_end();
    frame_begin();
    spi_byte(8'h04, "t7b_id", 1'b1, 8'h5A);
    spi_byte(8'h5C, "t7b_d", 1'b0, 8'h00);
    frame_end();
    model[4] = 8'h5C;
    frame_begin();
    spi_byte(8'h84, "t7c_id", 1'b1, 8'h5A);
    spi_byte(8'h00, "t7c_rd", 1'b1, model[4]);
    frame_end();
    check_all_regs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
# spi_responder

SPI target that answers the bit-banged SPI master on the Gigatron extension board (SCK/MOSI/nSS driven from ctrl-code writes, MISO sampled through the port-0 read path). It oversamples SCK, nSS and MOSI on a single fast system clock. It decodes a one-byte command followed by data bytes, and exposes a 16 x 8 register file to local logic. Used as a peripheral on companion boards and as the bus-functional target in board-level benches.

## Interface
- CPOL, 0, SCK idle level; 0 = mode 0, 1 = mode 2. CPHA is fixed at 0.
- IDBYTE, 8'h5A, byte shifted out on MISO during every command byte.
- CLK  in  1  system clock; must be at least 8x the SCK frequency.
- RST  in  1  reset, asynchronous and active-high.
- SCK  in  1  SPI clock from master (asynchronous).
- nSS  in  1  slave select, active low (asynchronous).
- MOSI  in  1  master data.
- MISO  out  1  target data.
- MISO_OE  out  1  MISO drive enable; tristate buffer sits outside the block.
- LADDR  in  4  local register address.
- LWE  in  1  local write strobe, one CLK.
- LWDATA  in  8  local write data.
- LRDATA  out  8  register[LADDR], combinational.
- WSTB  out  1  one-CLK pulse when an SPI write commits.
- WADDR  out  4  address of the last SPI write commit.

## Operation
- Synchronization
  - SCK, nSS and MOSI each pass through a 2-FF synchronizer.
  - SCK is then delayed one more flop to produce `lead` (sample) and `trail` (shift) edge pulses.
  - With CPOL=0, lead is a rising edge. With CPOL=1, lead is a falling edge.
- Bit layer
  - On lead, synchronized MOSI shifts into rx_shift, MSB first, and the 3-bit bit counter increments.
  - On trail, tx_shift shifts left and MISO takes the new bit 7.
  - When the bit counter wraps 7->0, the byte is complete.
- Frame boundaries
  - A synchronized nSS falling edge starts a frame: bit counter <= 0, tx_shift <= IDBYTE, MISO <= IDBYTE[7], MISO_OE <= 1.
  - A synchronized nSS rising edge ends the frame: MISO_OE <= 0, MISO <= 0, FSM <= IDLE, partial byte discarded, no write.
- FSM states: IDLE, CMD, WDATA, RDATA, SKIP.
  - IDLE -> CMD on frame start.
  - CMD, byte complete: bit7=0 selects write, bit7=1 selects read; addr <= byte[3:0]; bits 6:4 are ignored.
    - Write -> WDATA.
    - Read -> RDATA, and tx_shift <= reg[addr] is loaded so its bit 7 appears on the next trail.
  - WDATA, byte complete: reg[addr] <= byte, WSTB pulses, WADDR <= addr. Next state follows Configuration.
  - RDATA, byte complete: next state follows Configuration. MOSI content is ignored.
  - SKIP: ignores everything and shifts 8'h00 out until the frame ends.
- Collisions
  - An SPI commit and an LWE in the same CLK at the same address: the SPI write wins.
  - At different addresses, both writes land.
- Read snapshot: RDATA shifts out the register value captured at the load instant. Later local writes do not alter the byte in flight.
- Address arithmetic is 4-bit and wraps 4'hF -> 4'h0.

## Timing
- Reset values: MISO=0, MISO_OE=0, WSTB=0, WADDR=0, all registers 8'h00, FSM=IDLE, bit counter 0, tx_shift=IDBYTE.
- Pin-to-action latency: 3 CLK. Pin edge -> 2 sync flops -> edge flop; the action occurs in the following CLK.
- MISO changes 3-4 CLK after the SCK trail edge. The master samples on the next lead edge at least 4 CLK later.
- Register load on the 8th lead edge completes 1 CLK before the trail edge shifts out bit 7.
- WSTB is asserted for exactly 1 CLK, 1 CLK after the 8th lead edge of the data byte.
- An nSS rise coincident with the 8th lead edge of a data byte: the edge is processed first and the write commits.
- RST asserted mid-frame: immediate return to reset values. The current frame is ignored until the next nSS falling edge.

## Configuration
- SPI_RESP_AUTOINC_EN
  - Defined: after each WDATA/RDATA byte, addr <= addr+1 (wrapping) and the FSM stays in WDATA/RDATA. Bursts of any length are allowed.
  - Undefined: after the first data byte the FSM goes to SKIP. Further bytes in the frame cause no writes and return 8'h00.

## Structure
- Shared package `spi_resp_pkg`: FSM state enum, command bit positions (CMD_RD_BIT=7, CMD_ADDR_LSB/MSB), NREGS=16.
- One sub-module, `spi_sync_edge`: 2-FF synchronizer plus edge detector, instantiated three times. Its outputs are level, rise and fall.

## Test plan
- Reset, then a frame with command 8'h03 and data 8'hC7 → reg[3]=8'hC7; WSTB pulses once with WADDR=3; MISO returns 8'h5A during the command byte.
- LWE writes 8'h96 to reg[9]; SPI frame with 8'h89 plus a dummy byte → MISO returns 8'h5A then 8'h96; LRDATA with LADDR=9 reads 8'h96.
- Burst write with command 8'h0F and data 11,22,33: with the _EN macro defined → reg[F]=11, reg[0]=22, reg[1]=33; undefined → only reg[F]=11, MISO returns 00 00 after the first data byte.
- nSS deasserted after 5 bits of a data byte → no WSTB and the register is unchanged; the next frame works normally.
- SPI commit and LWE to reg[2] in the same CLK (SPI 8'hAA, local 8'h55) → reg[2]=8'hAA.
- RST pulsed mid-burst → all registers 00, MISO_OE=0 immediately; after RST release a new frame decodes correctly.
